// File: rtl/gate_sensor_decoder.sv
// gate_sensor_decoder: synchronises and debounces two gate beam sensors and decodes entry/exit passages
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   beam_a       raw outer sensor, 1 = blocked
//   beam_b       raw inner sensor, 1 = blocked
//   entry_pulse  one-cycle pulse per completed entry
//   exit_pulse   one-cycle pulse per completed exit
//   mode_entry   1 after the last completed event was an entry, 0 after an exit
//   busy         FSM outside IDLE
//   fault        FSM in FAULT
//   dbg_state    current FSM state encoding
module gate_sensor_decoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       beam_a,
    input  logic       beam_b,
    output logic       entry_pulse,
    output logic       exit_pulse,
    output logic       mode_entry,
    output logic       busy,
    output logic       fault,
    output logic [2:0] dbg_state
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        A_IN     = 3'd1,
        BOTH_IN  = 3'd2,
        B_IN     = 3'd3,
        B_OUT    = 3'd4,
        BOTH_OUT = 3'd5,
        A_OUT    = 3'd6,
        FAULT    = 3'd7
    } state_t;
    localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    // bit 1 = a, bit 0 = b, so 2'b10 reads as "a blocked, b clear"
    logic [1:0]  sync1, sync2, ab;
    logic [7:0]  dcnt [2];
    logic [15:0] tcnt;
    state_t      state, nxt;
    logic        timed, ent, ext;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= '0;
            sync2   <= '0;
            ab      <= '0;
            dcnt[0] <= '0;
            dcnt[1] <= '0;
        end else begin
            sync1 <= {beam_a, beam_b};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == ab[i]) dcnt[i] <= '0;
                else if (dcnt[i] == DB_LAST) begin
                    dcnt[i] <= '0;
                    ab[i]   <= sync2[i];
                end else dcnt[i] <= dcnt[i] + 8'd1;
            end
        end
    end
    assign timed     = state != IDLE && state != FAULT;
    assign ent       = state == B_IN && ab == 2'b00;
    assign ext       = state == A_OUT && ab == 2'b00;
    assign dbg_state = state;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = ab == 2'b10 ? A_IN : ab == 2'b01 ? B_OUT : ab == 2'b11 ? FAULT : IDLE;
            A_IN:     nxt = ab == 2'b11 ? BOTH_IN : ab == 2'b00 ? IDLE : ab == 2'b01 ? FAULT : A_IN;
            BOTH_IN:  nxt = ab == 2'b01 ? B_IN : ab == 2'b10 ? A_IN : ab == 2'b00 ? FAULT : BOTH_IN;
            B_IN:     nxt = ab == 2'b00 ? IDLE : ab == 2'b11 ? BOTH_IN : ab == 2'b10 ? FAULT : B_IN;
            B_OUT:    nxt = ab == 2'b11 ? BOTH_OUT : ab == 2'b00 ? IDLE : ab == 2'b10 ? FAULT : B_OUT;
            BOTH_OUT: nxt = ab == 2'b10 ? A_OUT : ab == 2'b01 ? B_OUT : ab == 2'b00 ? FAULT : BOTH_OUT;
            A_OUT:    nxt = ab == 2'b00 ? IDLE : ab == 2'b11 ? BOTH_OUT : ab == 2'b01 ? FAULT : A_OUT;
            default:  nxt = ab == 2'b00 ? IDLE : FAULT;
        endcase
        // a real sensor transition wins over a timeout landing in the same cycle
        if (timed && nxt == state && tcnt == TO_LAST) nxt = FAULT;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tcnt        <= '0;
            entry_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
            mode_entry  <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= nxt;
            tcnt        <= (timed && nxt == state) ? tcnt + 16'd1 : '0;
            entry_pulse <= ent;
            exit_pulse  <= ext;
            mode_entry  <= ent | (mode_entry & ~ext);
            busy        <= nxt != IDLE;
            fault       <= nxt == FAULT;
        end
    end
endmodule

// File: tb/tb_gate_sensor_decoder.sv
// tb_gate_sensor_decoder: vector table, directed corner sequences and random stimulus against a passage model
module tb_gate_sensor_decoder;
    localparam int DB = 4;
    localparam int TO = 64;
    logic       clk = 1'b0, rst = 1'b0, beam_a = 1'b0, beam_b = 1'b0;
    logic       entry_pulse, exit_pulse, mode_entry, busy, fault;
    logic [2:0] dbg_state;
    int total = 0, bad = 0, ent_cnt = 0, ext_cnt = 0;

    gate_sensor_decoder #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .beam_a(beam_a), .beam_b(beam_b),
        .entry_pulse(entry_pulse), .exit_pulse(exit_pulse), .mode_entry(mode_entry),
        .busy(busy), .fault(fault), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // passage model: a passage is a walk along a fixed pattern of sensor codes;
    // stepping forward/back along it is legal, anything else is a fault
    bit [1:0] pat [2][3] = '{'{2'b10, 2'b11, 2'b01}, '{2'b01, 2'b11, 2'b10}};
    bit [1:0] rq[$], sq[$];
    bit [1:0] m_stab = 2'b00, m_ab = 2'b00, seen = 2'b00;
    int  m_st = 0, m_idx = 0, m_dir = 0, nst = 0, nidx = 0, cyc = 0, t_in = 0;
    bit  m_mode = 0, m_ent = 0, m_ext = 0, diff = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rq = '{2'b00, 2'b00};
            sq = {};
            repeat (DB) sq.push_back(2'b00);
            m_stab = 0; m_st = 0; m_idx = 0; m_dir = 0; m_mode = 0;
            m_ent = 0; m_ext = 0; cyc = 0; t_in = 0;
        end else begin
            cyc++;
            m_ab = m_stab; m_ent = 0; m_ext = 0; nst = m_st; nidx = m_idx;
            if (m_st == 0) begin
                if (m_ab == 2'b11) nst = 2;
                else if (m_ab != 2'b00) begin nst = 1; m_dir = (m_ab == 2'b01) ? 1 : 0; nidx = 0; end
            end else if (m_st == 2) begin
                if (m_ab == 2'b00) nst = 0;
            end else begin
                if (m_ab == pat[m_dir][m_idx]) begin
                    if (cyc - t_in == TO) nst = 2;
                end else if (m_idx < 2 && m_ab == pat[m_dir][m_idx + 1]) nidx = m_idx + 1;
                else if (m_idx > 0 && m_ab == pat[m_dir][m_idx - 1]) nidx = m_idx - 1;
                else if (m_ab == 2'b00 && m_idx == 0) nst = 0;
                else if (m_ab == 2'b00 && m_idx == 2) begin
                    nst = 0;
                    if (m_dir == 1) m_ext = 1; else m_ent = 1;
                end else nst = 2;
            end
            if (nst != m_st || nidx != m_idx) t_in = cyc;
            m_st = nst; m_idx = nidx;
            if (m_ent) m_mode = 1;
            if (m_ext) m_mode = 0;
            // two-cycle delay line, then a level only moves after DB consecutive disagreeing samples
            seen = rq.pop_front();
            rq.push_back({beam_a, beam_b});
            sq.push_back(seen);
            if (sq.size() > DB) void'(sq.pop_front());
            for (int k = 0; k < 2; k++) begin
                diff = 1;
                foreach (sq[j]) if (sq[j][k] == m_stab[k]) diff = 0;
                if (diff) m_stab[k] = ~m_stab[k];
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        bit st_ok;
        @(posedge clk);
        @(negedge clk);
        ent_cnt += int'(entry_pulse);
        ext_cnt += int'(exit_pulse);
        st_ok = (m_st == 0) ? (dbg_state == 3'd0) : (m_st == 2) ? (dbg_state == 3'd7) :
                (dbg_state != 3'd0 && dbg_state != 3'd7);
        total++;
        if ({entry_pulse, exit_pulse, mode_entry, busy, fault} !==
            {m_ent, m_ext, m_mode, m_st != 0, m_st == 2} || !st_ok) begin
            bad++;
            $display("FAIL model t=%0t got ep=%b xp=%b me=%b bz=%b ft=%b st=%0d expected ep=%b xp=%b me=%b bz=%b ft=%b class=%0d",
                     $time, entry_pulse, exit_pulse, mode_entry, busy, fault, dbg_state,
                     m_ent, m_ext, m_mode, m_st != 0, m_st == 2, m_st);
        end
    endtask

    task automatic hold(input bit [1:0] ab, input int n);
        beam_a = ab[1];
        beam_b = ab[0];
        repeat (n) tick();
    endtask

    typedef struct {
        bit [1:0] ab;
        int       hold;
        bit       busy_e;
        bit       fault_e;
        bit       mode_e;
        int       ent_e;
        int       ext_e;
    } vec_t;
    vec_t vt[$];

    initial begin
        int nz, lat, t_busy, t_fault, t_idle, moved, sel, d;
        vt.push_back('{2'b10, 20, 1, 0, 0, 0, 0});
        vt.push_back('{2'b11, 20, 1, 0, 0, 0, 0});
        vt.push_back('{2'b01, 20, 1, 0, 0, 0, 0});
        vt.push_back('{2'b00, 20, 0, 0, 1, 1, 0});
        vt.push_back('{2'b01, 20, 1, 0, 1, 0, 0});
        vt.push_back('{2'b11, 20, 1, 0, 1, 0, 0});
        vt.push_back('{2'b10, 20, 1, 0, 1, 0, 0});
        vt.push_back('{2'b00, 20, 0, 0, 0, 0, 1});
        vt.push_back('{2'b10, 20, 1, 0, 0, 0, 0});
        vt.push_back('{2'b00, 20, 0, 0, 0, 0, 0});
        vt.push_back('{2'b10, 20, 1, 0, 0, 0, 0});
        vt.push_back('{2'b11, 20, 1, 0, 0, 0, 0});
        vt.push_back('{2'b10, 20, 1, 0, 0, 0, 0});
        vt.push_back('{2'b00, 20, 0, 0, 0, 0, 0});
        vt.push_back('{2'b11, 20, 1, 1, 0, 0, 0});
        vt.push_back('{2'b00, 20, 0, 0, 0, 0, 0});
        vt.push_back('{2'b01, 20, 1, 0, 0, 0, 0});
        vt.push_back('{2'b10, 20, 1, 1, 0, 0, 0});
        vt.push_back('{2'b00, 20, 0, 0, 0, 0, 0});

        nz = 0;
        for (int i = 0; i < 12; i++) begin
            beam_a = i[0];
            beam_b = i[1];
            tick();
            if (entry_pulse | exit_pulse | mode_entry | busy | fault | (dbg_state != 3'd0)) nz++;
        end
        check("reset_outputs", nz, 0);
        rst = 1'b1;
        hold(2'b00, 10);
        check("post_reset_state", int'(dbg_state), 0);
        check("post_reset_busy", int'(busy), 0);

        foreach (vt[i]) begin
            ent_cnt = 0;
            ext_cnt = 0;
            hold(vt[i].ab, vt[i].hold);
            check($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].busy_e));
            check($sformatf("vec%0d_fault", i), int'(fault), int'(vt[i].fault_e));
            check($sformatf("vec%0d_mode", i), int'(mode_entry), int'(vt[i].mode_e));
            check($sformatf("vec%0d_entries", i), ent_cnt, vt[i].ent_e);
            check($sformatf("vec%0d_exits", i), ext_cnt, vt[i].ext_e);
        end

        hold(2'b10, 20);
        hold(2'b11, 20);
        hold(2'b01, 20);
        beam_b = 1'b0;
        ent_cnt = 0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (entry_pulse && lat < 0) lat = k;
        end
        check("entry_latency", lat, 7);
        check("entry_width", ent_cnt, 1);
        check("entry_mode", int'(mode_entry), 1);

        moved = 0;
        beam_a = 1'b1;
        repeat (3) tick();
        beam_a = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (dbg_state != 3'd0) moved = 1;
        end
        check("glitch3_moved", moved, 0);
        moved = 0;
        ent_cnt = 0;
        ext_cnt = 0;
        beam_a = 1'b1;
        repeat (4) tick();
        beam_a = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (dbg_state != 3'd0) moved = 1;
        end
        check("glitch4_moved", moved, 1);
        check("glitch4_pulses", ent_cnt + ext_cnt, 0);
        check("glitch4_back_idle", int'(dbg_state), 0);

        t_busy = -1;
        t_fault = -1;
        beam_a = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (busy && t_busy < 0) t_busy = k;
            if (fault && t_fault < 0) t_fault = k;
        end
        check("timeout_delay", (t_fault < 0) ? -1 : t_fault - t_busy, TO);
        check("timeout_fault_state", int'(dbg_state), 7);
        t_idle = -1;
        beam_a = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (!busy && t_idle < 0) t_idle = k;
        end
        check("fault_clear_latency", t_idle, 7);

        hold(2'b10, 20);
        hold(2'b11, 20);
        hold(2'b01, 20);
        rst = 1'b0;
        repeat (3) tick();
        beam_a = 1'b0;
        beam_b = 1'b0;
        rst = 1'b1;
        ent_cnt = 0;
        hold(2'b00, 20);
        check("midreset_entries", ent_cnt, 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_mode", int'(mode_entry), 0);

        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 2));
            if (sel == 0) begin
                d = int'($urandom_range(0, 1));
                for (int s = 0; s < 3; s++) hold(pat[d][s], int'($urandom_range(8, 30)));
                hold(2'b00, int'($urandom_range(8, 30)));
            end else if ($urandom_range(0, 7) == 0) begin
                hold(2'($urandom_range(0, 3)), int'($urandom_range(60, 80)));
            end else begin
                hold(2'($urandom_range(0, 3)), int'($urandom_range(1, 12)));
            end
        end
        hold(2'b00, 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
